// File: rtl/dmux4way_dispatcher_pkg.sv
// Shared mode and state encodings for the DMux4Way dispatcher.
// Optional statistics are enabled with DISPATCH_STATS_EN.
package dmux4way_dispatcher_pkg;

    localparam logic DISPATCH_MODE_DIRECT = 1'b0;
    localparam logic DISPATCH_MODE_RR     = 1'b1;

    typedef enum logic {
        DISP_EMPTY = 1'b0,
        DISP_FULL  = 1'b1
    } disp_state_t;

    localparam int CNT_W = 8;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/DMux4Way.sv
// 1-to-4 demultiplexer: routes a single bit onto one of four outputs.
// Non-selected outputs are held low.
module DMux4Way (
    input  logic       in,
    input  logic [1:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
);

    assign a = in & (sel == 2'd0);
    assign b = in & (sel == 2'd1);
    assign c = in & (sel == 2'd2);
    assign d = in & (sel == 2'd3);

endmodule

// File: rtl/dmux4way_dispatcher.sv
// One-word skid dispatcher feeding DMux4Way from a registered select.
// Define DISPATCH_STATS_EN to add per-channel saturating handshake counters.
module dmux4way_dispatcher
    import dmux4way_dispatcher_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
`ifdef DISPATCH_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      stat_cnt
`endif
);

    disp_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;
    logic [1:0]       rr_ptr;
    logic             full;
    logic             hs;
    logic             accept;

    assign full   = (state_q == DISP_FULL);
    assign hs     = full && out_ready[sel_q];
    // Gate with reset so the producer never sees ready during reset.
    assign in_ready = !reset && (!full || out_ready[sel_q]);
    assign accept   = in_ready && in_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DISP_EMPTY: if (in_valid) state_d = DISP_FULL;
            DISP_FULL:  if (hs && !in_valid) state_d = DISP_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DISP_EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            rr_ptr  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= in_data;
                sel_q  <= (mode == DISPATCH_MODE_RR) ? rr_ptr : in_dest;
                if (mode == DISPATCH_MODE_RR)
                    rr_ptr <= rr_next(rr_ptr);
            end
        end
    end

    DMux4Way u_dmux (
        .in  (full),
        .sel (sel_q),
        .a   (out_valid[0]),
        .b   (out_valid[1]),
        .c   (out_valid[2]),
        .d   (out_valid[3])
    );

    assign out_data = data_q;
    assign out_sel  = sel_q;

`ifdef DISPATCH_STATS_EN
    logic [3:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stat_clr) begin
            cnt_q <= '0;
        end else if (hs && (cnt_q[sel_q] != '1)) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
        end
    end

    assign stat_cnt = cnt_q;
`endif

endmodule
